// File: rtl/adc_frontend.sv
`default_nettype none
// ============================================================================
// adc_frontend : saturating offset + Q8.8 gain, optional 2^k block averaging,
//                overrange stretcher and windowed min/max/count statistics.
// Revision: 1.0
// ============================================================================
module adc_frontend #(
    parameter int WIDTH        = 8,
    parameter int GAIN_W       = 16,
    parameter int STRETCH_W    = 24,
    parameter int CNT_W        = 32,
    parameter int DEC_LOG2_MAX = 4,
    localparam int KW          = $clog2(DEC_LOG2_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_i,
    input  logic                 valid_in_i,
    input  logic [WIDTH-1:0]     offset_i,
    input  logic [GAIN_W-1:0]    gain_i,
    input  logic                 mode_i,
    input  logic [KW-1:0]        dec_log2_i,
    output logic [WIDTH-1:0]     out_o,
    output logic                 valid_out_o,
    output logic                 sat_out_o,
    input  logic                 dor_in_i,
    input  logic [STRETCH_W-1:0] stretch_len_i,
    output logic                 dor_out_o,
    input  logic                 stat_clear_i,
    input  logic                 stat_enable_i,
    input  logic [CNT_W-1:0]     stat_limit_i,
    output logic [WIDTH-1:0]     stat_min_o,
    output logic [WIDTH-1:0]     stat_max_o,
    output logic [CNT_W-1:0]     stat_count_o,
    output logic                 stat_done_o
);
    localparam int ACC_W  = WIDTH + DEC_LOG2_MAX;
    localparam int PROD_W = WIDTH + GAIN_W;
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DEC_LOG2_MAX:0]   BLK_ONE = (DEC_LOG2_MAX + 1)'(1);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

    // ---------------- stage 1 : saturating offset ----------------
    logic signed [WIDTH:0]   sum1_w;
    logic signed [WIDTH-1:0] s1_d, s1_q;
    logic                    s1_sat_d, s1_sat_q, s1_v_q;

    always_comb begin
        sum1_w   = {in_i[WIDTH-1], in_i} + {offset_i[WIDTH-1], offset_i};
        s1_sat_d = (sum1_w[WIDTH] != sum1_w[WIDTH-1]);
        s1_d     = s1_sat_d ? (sum1_w[WIDTH] ? SMIN : SMAX) : sum1_w[WIDTH-1:0];
    end

    // ---------------- stage 2 : saturating Q8.8 gain ----------------
    logic signed [PROD_W-1:0] prod_w, shr_w;
    logic                     s2_ovf_w;
    logic signed [WIDTH-1:0]  s2_d, s2_q;
    logic                     s2_sat_q, s2_v_q;

    always_comb begin
        prod_w   = PROD_W'(s1_q) * PROD_W'($signed(gain_i));
        shr_w    = prod_w >>> 8;
        // in range only when every bit above the result sign bit matches it
        s2_ovf_w = !((&shr_w[PROD_W-1:WIDTH-1]) || (~|shr_w[PROD_W-1:WIDTH-1]));
        s2_d     = s2_ovf_w ? (shr_w[PROD_W-1] ? SMIN : SMAX) : shr_w[WIDTH-1:0];
    end

    // ---------------- stage 3 : pass-through or block average ----------------
    logic [KW-1:0]            k_eff_w, k_q;
    logic                     mode_q, cfg_chg_w;
    logic [DEC_LOG2_MAX:0]    blk_w, cnt_d, cnt_q, cnt_inc_w;
    logic signed [ACC_W-1:0]  acc_d, acc_q, acc_sum_w, avg_w;
    logic                     bsat_d, bsat_q;
    logic [WIDTH-1:0]         out_d, out_q;
    logic                     vout_d, vout_q, sout_d, sout_q;

    always_comb begin
        k_eff_w   = (dec_log2_i > KW'(DEC_LOG2_MAX)) ? KW'(DEC_LOG2_MAX) : dec_log2_i;
        blk_w     = BLK_ONE << k_eff_w;
        cfg_chg_w = (mode_i != mode_q) || (k_eff_w != k_q);
        cnt_inc_w = cnt_q + BLK_ONE;
        acc_sum_w = acc_q + ACC_W'(s2_q);
        avg_w     = acc_sum_w >>> k_eff_w;

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        bsat_d = bsat_q;
        out_d  = out_q;
        vout_d = 1'b0;
        sout_d = sout_q;

        if (s2_v_q && !mode_i) begin
            out_d  = s2_q;
            vout_d = 1'b1;
            sout_d = s2_sat_q;
        end

        // a config change drops whatever partial block was in progress
        if (cfg_chg_w || !mode_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            bsat_d = 1'b0;
        end else if (s2_v_q) begin
            if (cnt_inc_w == blk_w) begin
                out_d  = avg_w[WIDTH-1:0];
                vout_d = 1'b1;
                sout_d = bsat_q | s2_sat_q;
                acc_d  = '0;
                cnt_d  = '0;
                bsat_d = 1'b0;
            end else begin
                acc_d  = acc_sum_w;
                cnt_d  = cnt_inc_w;
                bsat_d = bsat_q | s2_sat_q;
            end
        end
    end

    // ---------------- overrange stretcher / statistics next state ----------------
    logic [STRETCH_W-1:0]    str_d, str_q;
    logic signed [WIDTH-1:0] smin_d, smin_q, smax_d, smax_q;
    logic [CNT_W-1:0]        scnt_d, scnt_q, scnt_inc_w;
    logic                    sdone_d, sdone_q;

    always_comb begin
        str_d = str_q;
        if (dor_in_i)
            str_d = stretch_len_i;
        else if (str_q != '0)
            str_d = str_q - STRETCH_W'(1);

        scnt_inc_w = scnt_q + CNT_ONE;
        smin_d     = smin_q;
        smax_d     = smax_q;
        scnt_d     = scnt_q;
        sdone_d    = sdone_q;
        if (stat_clear_i) begin
            smin_d  = SMAX;
            smax_d  = SMIN;
            scnt_d  = '0;
            sdone_d = 1'b0;
        end else if (valid_in_i && stat_enable_i && !sdone_q) begin
            if ($signed(in_i) < smin_q) smin_d = $signed(in_i);
            if ($signed(in_i) > smax_q) smax_d = $signed(in_i);
            scnt_d  = scnt_inc_w;
            sdone_d = (stat_limit_i != '0) && (scnt_inc_w == stat_limit_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_sat_q <= 1'b0;
            s1_v_q   <= 1'b0;
            s2_q     <= '0;
            s2_sat_q <= 1'b0;
            s2_v_q   <= 1'b0;
            mode_q   <= 1'b0;
            k_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bsat_q   <= 1'b0;
            out_q    <= '0;
            vout_q   <= 1'b0;
            sout_q   <= 1'b0;
            str_q    <= '0;
            smin_q   <= SMAX;
            smax_q   <= SMIN;
            scnt_q   <= '0;
            sdone_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s1_sat_q <= s1_sat_d;
            s1_v_q   <= valid_in_i;
            s2_q     <= s2_d;
            s2_sat_q <= s1_sat_q | s2_ovf_w;
            s2_v_q   <= s1_v_q;
            mode_q   <= mode_i;
            k_q      <= k_eff_w;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bsat_q   <= bsat_d;
            out_q    <= out_d;
            vout_q   <= vout_d;
            sout_q   <= sout_d;
            str_q    <= str_d;
            smin_q   <= smin_d;
            smax_q   <= smax_d;
            scnt_q   <= scnt_d;
            sdone_q  <= sdone_d;
        end
    end

    assign out_o        = out_q;
    assign valid_out_o  = vout_q;
    assign sat_out_o    = sout_q;
    assign dor_out_o    = (str_q != '0);
    assign stat_min_o   = smin_q;
    assign stat_max_o   = smax_q;
    assign stat_count_o = scnt_q;
    assign stat_done_o  = sdone_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_frontend.sv
`default_nettype none
// tb_adc_frontend : directed and randomized stimulus against a behavioural
// model of the conditioning chain, stretcher and statistics window.
module tb_adc_frontend;
    localparam int W = 8, G = 16, SW = 24, CW = 32, DM = 4, KW = 3;
    localparam int VMAX = 127, VMIN = -128;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [W-1:0]  din = '0, offset = '0, dout, st_min, st_max;
    logic          vin = 1'b0, mode = 1'b0, vout, sout;
    logic [G-1:0]  gain = 16'h0100;
    logic [KW-1:0] dec_log2 = '0;
    logic          dor_in = 1'b0, dor_out;
    logic [SW-1:0] stretch_len = '0;
    logic          st_clr = 1'b0, st_en = 1'b0, st_done;
    logic [CW-1:0] st_lim = '0, st_cnt;

    always #5 clk = ~clk;

    adc_frontend #(.WIDTH(W), .GAIN_W(G), .STRETCH_W(SW), .CNT_W(CW), .DEC_LOG2_MAX(DM)) dut (
        .clk(clk), .rst_n(rst_n), .in_i(din), .valid_in_i(vin), .offset_i(offset),
        .gain_i(gain), .mode_i(mode), .dec_log2_i(dec_log2), .out_o(dout),
        .valid_out_o(vout), .sat_out_o(sout), .dor_in_i(dor_in),
        .stretch_len_i(stretch_len), .dor_out_o(dor_out), .stat_clear_i(st_clr),
        .stat_enable_i(st_en), .stat_limit_i(st_lim), .stat_min_o(st_min),
        .stat_max_o(st_max), .stat_count_o(st_cnt), .stat_done_o(st_done));

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct { bit v; int val; bit sat; } exp_t;
    exp_t pipe[$];
    int   acc_m, cnt_m, k_prev, edge_n, last_pulse, last_len, last_out, n_out;
    bit   bsat_m, mode_prev, last_sat;
    int   win[$];

    function automatic int clampw(longint x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return int'(x);
    endfunction

    task automatic model_reset();
        exp_t z;
        z.v = 0; z.val = 0; z.sat = 0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        acc_m = 0; cnt_m = 0; bsat_m = 0; mode_prev = 0; k_prev = 0;
        last_len = 0; last_pulse = 0;
        win.delete();
    endtask

    // One clock: capture inputs into the model, then compare every output.
    task automatic cycle();
        exp_t   e, o;
        int     s1, s2, kk, mn, mx;
        longint t;
        bit     sat, full;
        @(posedge clk);
        #1;
        edge_n++;
        e.v = 0; e.val = 0; e.sat = 0;
        kk = (int'(dec_log2) > DM) ? DM : int'(dec_log2);
        if (mode != mode_prev || kk != k_prev) begin
            acc_m = 0; cnt_m = 0; bsat_m = 0;
        end
        mode_prev = mode;
        k_prev    = kk;
        if (vin) begin
            t   = longint'($signed(din)) + longint'($signed(offset));
            s1  = clampw(t);
            sat = (s1 != t);
            t   = (longint'(s1) * longint'($signed(gain))) >>> 8;
            s2  = clampw(t);
            sat = sat | (s2 != t);
            if (!mode) begin
                e.v = 1; e.val = s2; e.sat = sat;
            end else begin
                acc_m += s2; bsat_m |= sat; cnt_m++;
                if (cnt_m == (1 << kk)) begin
                    e.v = 1; e.val = acc_m >>> kk; e.sat = bsat_m;
                    acc_m = 0; cnt_m = 0; bsat_m = 0;
                end
            end
        end
        pipe.push_back(e);
        o = pipe.pop_front();
        check("valid_out", vout, o.v);
        if (o.v) begin
            check("out", $signed(dout), o.val);
            check("sat_out", sout, o.sat);
        end
        if (vout) begin
            last_out = $signed(dout); last_sat = sout; n_out++;
        end

        if (dor_in) begin
            last_pulse = edge_n; last_len = int'(stretch_len);
        end
        check("dor_out", dor_out, (edge_n - last_pulse) < last_len);

        full = (st_lim != 0) && (win.size() == int'(st_lim));
        if (st_clr) win.delete();
        else if (vin && st_en && !full) win.push_back(int'($signed(din)));
        mn = VMAX; mx = VMIN;
        foreach (win[i]) begin
            if (win[i] < mn) mn = win[i];
            if (win[i] > mx) mx = win[i];
        end
        check("stat_min", $signed(st_min), mn);
        check("stat_max", $signed(st_max), mx);
        check("stat_count", st_cnt, win.size());
        check("stat_done", st_done, (st_lim != 0) && (win.size() == int'(st_lim)));
    endtask

    task automatic idle(input int n);
        vin = 0; dor_in = 0; st_clr = 0;
        repeat (n) cycle();
    endtask

    task automatic send(input int v);
        vin = 1; din = W'(v);
        cycle();
        vin = 0;
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1;
        check("rst_dor_out", dor_out, 0);
        check("rst_valid_out", vout, 0);
        check("rst_out", dout, 0);
        check("rst_stat_min", $signed(st_min), VMAX);
        check("rst_stat_max", $signed(st_max), VMIN);
        check("rst_stat_count", st_cnt, 0);
        #1 rst_n = 1;
        model_reset();
    endtask

    initial begin
        int hi, n0;
        model_reset();
        edge_n = 0; n_out = 0; last_out = 0; last_sat = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", dout, 0);
        check("reset_sat", sout, 0);
        check("reset_done", st_done, 0);
        check("reset_min", $signed(st_min), VMAX);
        check("reset_max", $signed(st_max), VMIN);
        @(negedge clk) rst_n = 1;

        // pass-through, then back-to-back
        send(8'h40); idle(3);
        check("pass_0x40", last_out, 64);
        n0 = n_out;
        for (int i = 0; i < 4; i++) send($urandom_range(0, 255));
        idle(3);
        check("b2b_count", n_out - n0, 4);

        // gain and offset saturation
        gain = 16'h0200; send(8'h50); idle(3);
        check("gain_pos_sat", last_out, 127); check("gain_pos_flag", last_sat, 1);
        send(8'hB0); idle(3);
        check("gain_neg_sat", last_out, -128); check("gain_neg_flag", last_sat, 1);
        gain = 16'hFF00; send(8'h10); idle(3);
        check("gain_minus1", last_out, -16); check("gain_minus1_flag", last_sat, 0);
        gain = 16'h0100; offset = 8'hCE; send(8'h9C); idle(3);
        check("offset_sat", last_out, -128); check("offset_flag", last_sat, 1);
        offset = 8'h00;

        // decimation
        mode = 1; dec_log2 = 2; idle(2);
        send(10); send(20); send(30); send(40); idle(3);
        check("dec_avg25", last_out, 25);
        send(-1); send(-1); send(-1); send(-2); idle(3);
        check("dec_floor", last_out, -2);
        n0 = n_out;
        send(7); send(9); idle(3);
        dec_log2 = 1; idle(3);
        check("dec_partial_dropped", n_out - n0, 0);
        send(7); send(9); idle(3);
        check("dec_after_change", last_out, 8);
        dec_log2 = 7; idle(2);
        for (int i = 0; i < 16; i++) send(i * 4);
        idle(3);
        check("dec_clamped16", last_out, 30);
        mode = 0; dec_log2 = 0; idle(2);

        // stretcher
        stretch_len = 5; dor_in = 1; cycle(); dor_in = 0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (dor_out) hi++;
            cycle();
        end
        check("stretch_len5", hi, 5);
        dor_in = 1; cycle(); dor_in = 0; cycle(); cycle();
        dor_in = 1; cycle(); dor_in = 0; idle(7);
        stretch_len = 0; dor_in = 1; cycle(); cycle(); dor_in = 0; idle(2);
        stretch_len = 9; dor_in = 1; cycle(); dor_in = 0; idle(2);
        async_reset();
        idle(2);

        // statistics
        st_clr = 1; st_lim = 4; cycle(); st_clr = 0; st_en = 1;
        send(5); send(-3); send(7); send(0); send(9);
        check("stat_min_win", $signed(st_min), -3);
        check("stat_max_win", $signed(st_max), 7);
        check("stat_cnt_win", st_cnt, 4);
        check("stat_done_win", st_done, 1);
        st_clr = 1; vin = 1; din = 8'd100; cycle(); st_clr = 0; vin = 0;
        check("stat_clr_cnt", st_cnt, 0);
        check("stat_clr_max", $signed(st_max), VMIN);
        idle(2);

        // randomized segments
        for (int seg = 0; seg < 12; seg++) begin
            idle(3);
            mode     = $urandom_range(0, 1);
            dec_log2 = KW'($urandom_range(0, 7));
            gain     = ($urandom_range(0, 1) != 0) ? G'($urandom_range(0, 16'hFFFF))
                                                   : G'($urandom_range(16'h0080, 16'h0180));
            offset   = W'($urandom_range(0, 255));
            st_lim   = CW'($urandom_range(0, 40));
            st_clr   = 1; cycle(); st_clr = 0;
            idle(2);
            for (int c = 0; c < 250; c++) begin
                vin         = ($urandom_range(0, 3) != 0);
                din         = W'($urandom_range(0, 255));
                dor_in      = ($urandom_range(0, 15) == 0);
                stretch_len = SW'($urandom_range(0, 10));
                st_en       = ($urandom_range(0, 4) != 0);
                st_clr      = ($urandom_range(0, 60) == 0);
                cycle();
            end
            if (seg == 5) async_reset();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adc_frontend.md
Name: adc_frontend

Overview:
- Parametrised successor to the single-channel ADC conditioning path.
- Takes signed ADC samples of WIDTH bits and applies a saturating offset, then a saturating Q8.8 gain.
- Optionally decimates by 2^k with block averaging, using the same conditioned stream.
- Also provides a programmable-length overrange stretcher and windowed min/max/count statistics. It sits between the ADC capture logic and the FIR/DSP chain; configuration is driven from the channel register bank.

Parameters:
- WIDTH, 8, sample width in bits (signed two's complement), 4..16
- GAIN_W, 16, gain width; unsigned-in-magnitude signed Q(GAIN_W-8).8 fixed point
- STRETCH_W, 24, width of overrange stretch length/counter
- CNT_W, 32, width of statistics limit/count
- DEC_LOG2_MAX, 4, maximum decimation exponent (factor up to 16)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in  in  WIDTH  signed input sample
- valid_in  in  1  sample strobe
- offset  in  WIDTH  signed offset added before gain
- gain  in  GAIN_W  signed gain, 0x0100 = 1.0
- mode  in  1  0 = pass every sample, 1 = decimate/average
- dec_log2  in  $clog2(DEC_LOG2_MAX+1)  decimation exponent k
- out  out  WIDTH  conditioned signed sample
- valid_out  out  1  output strobe
- sat_out  out  1  output sample was clipped at stage 1 or 2
- dor_in  in  1  ADC overrange input
- stretch_len  in  STRETCH_W  stretch length in cycles
- dor_out  out  1  stretched overrange
- stat_clear  in  1  synchronous clear of statistics
- stat_enable  in  1  statistics accumulate enable
- stat_limit  in  CNT_W  samples per statistics window
- stat_min  out  WIDTH  window minimum
- stat_max  out  WIDTH  window maximum
- stat_count  out  CNT_W  samples counted in current window
- stat_done  out  1  sticky, window complete

Behaviour:
- Reset (reset=0, async): all outputs 0, accumulators and counters 0, stat_min = +max (0x7F for WIDTH=8), stat_max = -min (0x80).
- Stage 1 (reg): s1 = in + offset computed at WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; records a stage-1 sat flag.
- Stage 2 (reg): p = s1 * gain (full precision), then arithmetic >>8, saturated to WIDTH; stage-2 sat flag ORs with the stage-1 flag.
- Stage 3 (reg) in mode 0: out/valid_out/sat_out register stage 2. Latency is 3 cycles from valid_in to valid_out; one output per input, and back-to-back inputs are supported.
- Stage 3 in mode 1, accumulation:
  - Accumulator is WIDTH+DEC_LOG2_MAX bits wide, signed.
  - Sample counter counts to 2^k. On the 2^k-th stage-2 valid, out = (acc + sample) >>> k (arithmetic, truncating toward -inf), valid_out=1 for one cycle, and sat_out = OR of the block's sat flags.
  - Accumulator and counter then restart.
- Mode 1 with k=0 behaves identically to mode 0.
- dec_log2 values above DEC_LOG2_MAX clamp to DEC_LOG2_MAX.
- A change of mode or dec_log2 (detected by registered compare) discards the partial block; no output is produced for it.
- Gain/offset changes take effect on the next sample entering the respective stage; there is no flush.
- dor stretcher:
  - dor_in=1 loads the counter with stretch_len; otherwise the counter decrements to 0. dor_out = (counter != 0).
  - stretch_len=0 gives dor_out=0 always.
  - dor_in held high keeps reloading.
- Statistics operate on raw `in` when valid_in and stat_enable:
  - Update min/max and increment stat_count.
  - When stat_count reaches stat_limit: stat_done=1 and counting freezes until stat_clear.
  - stat_clear has priority over a simultaneous sample; it restores the reset values of min/max/count/done.
  - stat_limit=0 means the window never completes.

Test Plan:
- Pass-through: mode=0, gain=0x0100, offset=0, in=0x40 valid at cycle 0 -> out=0x40, valid_out at cycle 3, sat_out=0; 4 back-to-back samples give 4 consecutive outputs.
- Gain saturation: gain=0x0200, in=0x50 -> out=0x7F, sat_out=1. in=0xB0 (-80) -> out=0x80, sat_out=1. gain=0xFF00 (-1.0), in=0x10 -> out=0xF0, sat_out=0.
- Offset saturation: offset=0xCE (-50), in=0x9C (-100) -> stage 1 = -128 -> out=0x80, sat_out=1 with gain 1.0.
- Decimate: mode=1, k=2, inputs 10,20,30,40 -> single output 25. Inputs -1,-1,-1,-2 -> output -2. Changing k after 2 samples -> no output for the partial block, next full block correct.
- Stretcher: stretch_len=5, 1-cycle dor_in pulse -> dor_out high exactly 5 cycles. Second pulse at cycle 3 -> high 5 cycles after that pulse. Async reset mid-stretch -> dor_out=0 immediately.
- Statistics: stat_limit=4, samples 5,-3,7,0,9 -> stat_min=-3, stat_max=7, stat_count=4, stat_done=1, and the 5th sample is ignored. stat_clear together with a sample -> reset values and count=0.
